// File: rtl/cdc_dst.sv
// Receiving half of a two-phase (toggle) req/ack crossing. It synchronises the
// request toggle, captures the word the source holds and offers it on valid/ready.
//  state   | meaning
//  S_IDLE  | no word held; waiting for a request toggle
//  S_VALID | data_o holds a word until ready_i accepts it
module cdc_dst #(
  parameter type         T           = logic [31:0],
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_req_i,
  input  T     async_data_i,
  output logic async_ack_o,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  typedef enum logic {S_IDLE, S_VALID} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] req_sync_q;
  logic                   req_prev_q;
  logic                   new_req;
  logic                   load;
  logic                   accept;
  logic                   ack_q;
  T                       data_q;

  // req_prev keeps tracking in S_VALID so a forbidden early toggle is dropped
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_sync_q <= '0;
      req_prev_q <= 1'b0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], async_req_i};
      req_prev_q <= req_sync_q[SYNC_STAGES-1];
    end
  end

  assign new_req = req_sync_q[SYNC_STAGES-1] ^ req_prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (new_req) state_d = S_VALID;
      S_VALID: if (ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    accept = 1'b0;
    case (state_q)
      S_IDLE:  load   = new_req;
      S_VALID: accept = ready_i;
      default: ;
    endcase
  end

  // Data is sampled only on the capture edge; the source holds it until ack returns
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      if (load)   data_q <= async_data_i;
      if (accept) ack_q  <= ~ack_q;
    end
  end

  assign valid_o     = (state_q == S_VALID);
  assign data_o      = data_q;
  assign async_ack_o = ack_q;

endmodule

// File: tb/tb_cdc_dst.sv
// Bench for cdc_dst: directed transfers with a queue of expected words that a
// negedge monitor pops on every accepted word.
module tb_cdc_dst;

  logic clk = 1'b0;
  logic src_clk = 1'b0;
  always #5 clk = ~clk;
  always #14 src_clk = ~src_clk;

  logic        rst;
  logic        req, ack, valid, ready;
  logic [31:0] data, dout;
  logic        req3, ack3, valid3, ready3;
  logic [31:0] data3, dout3;

  cdc_dst u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .async_req_i (req),
    .async_data_i(data),
    .async_ack_o (ack),
    .valid_o     (valid),
    .ready_i     (ready),
    .data_o      (dout)
  );

  cdc_dst #(.SYNC_STAGES(3)) u_dut3 (
    .clk_i       (clk),
    .rst_i       (rst),
    .async_req_i (req3),
    .async_data_i(data3),
    .async_ack_o (ack3),
    .valid_o     (valid3),
    .ready_i     (ready3),
    .data_o      (dout3)
  );

  int          checks = 0;
  int          errors = 0;
  int          rx_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] w);
    data = w;
    exp_q.push_back(w);
    req = ~req;
  endtask

  task automatic wait_valid(input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: valid_o still 0, expected 1 within %0d cycles", max_cycles);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    logic [31:0] k;
    k = 32'(i);
    return 32'hC0DE_0000 ^ (k * 32'h9E37_79B9);
  endfunction

  // Monitor: data order, hold stability under backpressure, ack toggle after accept
  logic        acc_prev = 1'b0, hold_prev = 1'b0;
  logic        ack_prev = 1'b0, ack_next = 1'b0;
  logic [31:0] dout_prev = '0;
  always @(negedge clk) begin
    if (rst) begin
      acc_prev  = 1'b0;
      hold_prev = 1'b0;
    end else begin
      if (acc_prev) begin
        check("mon_ack_toggle", ack, ack_next);
        check("mon_valid_drop", valid, 1'b0);
      end
      if (hold_prev) begin
        check("mon_hold_valid", valid, 1'b1);
        check("mon_hold_data", dout, dout_prev);
        check("mon_hold_ack", ack, ack_prev);
      end
      if (valid && ready) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected: got word %h, expected none", dout);
        end else begin
          check("mon_rx_data", dout, exp_q.pop_front());
        end
      end
      acc_prev  = valid && ready;
      hold_prev = valid && !ready;
      ack_next  = ~ack;
      ack_prev  = ack;
      dout_prev = dout;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  rx_base;
    bit  sending;
    bit  ok;

    rst    = 1'b1;
    req    = 1'($urandom);
    data   = $urandom;
    ready  = 1'($urandom);
    req3   = 1'b0;
    data3  = '0;
    ready3 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ack, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_data", dout, 32'h0);
    check("rst_valid3", valid3, 1'b0);
    req   = 1'b0;
    data  = '0;
    ready = 1'b1;
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_valid", valid, 1'b0);
    check("idle_ack", ack, 1'b0);

    // Single transfer, ready held high: valid three edges after the toggle
    @(posedge clk);
    #2 send(32'hDEAD_BEEF);
    repeat (2) @(posedge clk);
    #1 check("lat_early_valid", valid, 1'b0);
    @(posedge clk);
    #1;
    check("lat_valid", valid, 1'b1);
    check("lat_data", dout, 32'hDEAD_BEEF);
    check("lat_ack_before", ack, 1'b0);
    @(posedge clk);
    #1;
    check("pulse_valid", valid, 1'b0);
    check("pulse_ack", ack, 1'b1);

    // Backpressure for 10 cycles on a falling toggle
    @(posedge clk);
    #2;
    ready = 1'b0;
    send(32'hA5A5_5A5A);
    wait_valid(10);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", valid, 1'b1);
      check("bp_data", dout, 32'hA5A5_5A5A);
      check("bp_ack", ack, 1'b1);
    end
    #1 ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_ack", ack, 1'b0);
    check("bp_release_valid", valid, 1'b0);

    // Three-stage synchroniser: one extra cycle of latency
    @(posedge clk);
    #2;
    data3 = 32'h0BAD_F00D;
    req3  = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("sync3_early_valid", valid3, 1'b0);
    @(posedge clk);
    #1;
    check("sync3_valid", valid3, 1'b1);
    check("sync3_data", dout3, 32'h0BAD_F00D);

    // Stream from a source on an unrelated clock with random backpressure
    rx_base = rx_cnt;
    sending = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge src_clk);
          send(word_of(i));
          ok = 1'b0;
          for (int c = 0; c < 100; c++) begin
            @(posedge src_clk);
            if (ack == req) begin
              ok = 1'b1;
              break;
            end
          end
          if (!ok) begin
            checks++;
            errors++;
            $display("FAIL stream_ack_timeout: word %0d ack %b, expected %b", i, ack, req);
            break;
          end
        end
        sending = 1'b0;
      end
      begin
        while (sending) begin
          @(posedge clk);
          #2 ready = ($urandom_range(0, 3) != 0);
        end
        ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    check("stream_count", 32'(rx_cnt - rx_base), 32'd40);
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    // Mid-transfer reset with ack at 1: held word discarded, ack returns to 0
    @(posedge clk);
    #2 send(32'h1111_2222);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        ok = 1'b1;
        break;
      end
    end
    check("mrst_pre_ack", ack, 1'b1);
    @(posedge clk);
    #2;
    ready = 1'b0;
    send(32'h5555_AAAA);
    wait_valid(10);
    check("mrst_pre_valid", valid, 1'b1);
    #1;
    rst = 1'b1;
    req = 1'b0;
    #1;
    check("mrst_valid", valid, 1'b0);
    check("mrst_ack", ack, 1'b0);
    check("mrst_data", dout, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst     = 1'b0;
    rx_base = rx_cnt;
    ready   = 1'b1;
    send(32'h1234_5678);
    repeat (15) @(posedge clk);
    #1;
    check("mrst_one_word", 32'(rx_cnt - rx_base), 32'd1);
    check("mrst_queue_empty", 32'(exp_q.size()), 32'd0);
    check("mrst_ack_after", ack, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
